// File: rtl/sccb_init_sequencer.sv
// Walks the camera register-configuration ROM after power-up and issues one SCCB write
// per entry. Delay and end-marker entries are interpreted locally, and each write is watchdog-guarded.
module sccb_init_sequencer #(
    parameter int          ROM_DEPTH   = 76,
    parameter int          CLK_HZ      = 100_000_000,
    parameter int          PWRUP_MS    = 5,
    parameter logic [7:0]  DELAY_CODE  = 8'hF0,
    parameter logic [7:0]  END_CODE    = 8'hFF,
    parameter int          TIMEOUT_CYC = 200_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_req,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sccb_start,
    output logic [7:0]  sccb_reg_addr,
    output logic [7:0]  sccb_reg_data,
    input  logic        sccb_busy,
    input  logic        sccb_done,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [7:0]  cfg_count
);
    localparam int MS_CYC = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int PRE_W  = $clog2(MS_CYC + 1);
    localparam int WD_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(MS_CYC - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [15:0]      PWR_LAST  = 16'(PWRUP_MS - 1);
    localparam logic [7:0]       ADDR_LAST = 8'(ROM_DEPTH - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DELAY, S_NEXT, S_DONE
    } state_t;

    state_t           state_reg;
    logic [PRE_W-1:0] pre_reg;
    logic [15:0]      ms_cnt_reg;
    logic [WD_W-1:0]  wd_reg;
    logic             is_write_reg;
    logic             ms_tick;

    // Shared millisecond prescaler for the power-up wait and table delays
    assign ms_tick = (pre_reg == PRE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            pre_reg       <= '0;
            ms_cnt_reg    <= '0;
            wd_reg        <= '0;
            is_write_reg  <= 1'b0;
            rom_addr      <= '0;
            sccb_start    <= 1'b0;
            sccb_reg_addr <= '0;
            sccb_reg_data <= '0;
            cfg_busy      <= 1'b0;
            cfg_done      <= 1'b0;
            cfg_error     <= 1'b0;
            cfg_count     <= '0;
        end else begin
            sccb_start <= 1'b0;
            if (state_reg == S_PWRUP || state_reg == S_DELAY)
                pre_reg <= ms_tick ? '0 : pre_reg + 1'b1;

            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (init_req) begin
                        cfg_done   <= 1'b0;
                        cfg_error  <= 1'b0;
                        cfg_count  <= '0;
                        rom_addr   <= '0;
                        cfg_busy   <= 1'b1;
                        pre_reg    <= '0;
                        ms_cnt_reg <= '0;
                        state_reg  <= S_PWRUP;
                    end
                end
                S_PWRUP: begin
                    if (PWRUP_MS == 0) begin
                        state_reg <= S_FETCH;
                    end else if (ms_tick) begin
                        if (ms_cnt_reg == PWR_LAST)
                            state_reg <= S_FETCH;
                        else
                            ms_cnt_reg <= ms_cnt_reg + 16'd1;
                    end
                end
                S_FETCH: state_reg <= S_DECODE;
                S_DECODE: begin
                    is_write_reg <= 1'b0;
                    if (rom_data[15:8] == END_CODE) begin
                        cfg_busy  <= 1'b0;
                        cfg_done  <= 1'b1;
                        state_reg <= S_DONE;
                    end else if (rom_data[15:8] == DELAY_CODE) begin
                        ms_cnt_reg <= 16'(rom_data[7:0]);
                        pre_reg    <= '0;
                        state_reg  <= (rom_data[7:0] == 8'd0) ? S_NEXT : S_DELAY;
                    end else begin
                        sccb_reg_addr <= rom_data[15:8];
                        sccb_reg_data <= rom_data[7:0];
                        is_write_reg  <= 1'b1;
                        state_reg     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!sccb_busy) begin
                        sccb_start <= 1'b1;
                        wd_reg     <= '0;
                        state_reg  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // done wins over a simultaneous watchdog expiry
                    if (sccb_done) begin
                        state_reg <= S_NEXT;
                    end else if (wd_reg == WD_LAST) begin
                        cfg_error <= 1'b1;
                        state_reg <= S_NEXT;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end
                S_DELAY: begin
                    if (ms_tick) begin
                        ms_cnt_reg <= ms_cnt_reg - 16'd1;
                        if (ms_cnt_reg == 16'd1)
                            state_reg <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (is_write_reg && cfg_count != 8'hFF)
                        cfg_count <= cfg_count + 8'd1;
                    if (rom_addr == ADDR_LAST) begin
                        cfg_busy  <= 1'b0;
                        cfg_done  <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        rom_addr  <= rom_addr + 8'd1;
                        state_reg <= S_FETCH;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/sccb_init_sequencer.md
Name: sccb_init_sequencer

Overview:
- Controller that configures the camera after power-up by walking the register-configuration ROM and issuing one SCCB write per entry to the SCCB byte-write engine.
- Sits between the config ROM and the SCCB master. Owns rom_addr, the transaction start strobe and stable reg_addr/reg_data.
- Interprets delay and end-marker entries, guards each transaction with a watchdog, and reports progress and completion to top-level video logic.

Parameters:
- ROM_DEPTH, 76, number of ROM entries; last valid address is ROM_DEPTH-1.
- CLK_HZ, 100_000_000, clk frequency; one ms = CLK_HZ/1000 cycles.
- PWRUP_MS, 5, wait after init_req before the first ROM fetch.
- DELAY_CODE, 8'hF0, entry reg_addr meaning "wait reg_data ms, no write".
- END_CODE, 8'hFF, entry reg_addr meaning "end of table".
- TIMEOUT_CYC, 200_000, max cycles from sccb_start to sccb_done.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- init_req  in  1  1-cycle pulse; starts or restarts configuration (honoured in IDLE/DONE only).
- rom_addr  out  8  config ROM address.
- rom_data  in  16  {reg_addr, reg_data}; synchronous ROM, valid 1 cycle after rom_addr.
- sccb_start  out  1  1-cycle pulse requesting one SCCB 3-phase write.
- sccb_reg_addr  out  8  register address for the current write.
- sccb_reg_data  out  8  register data for the current write.
- sccb_busy  in  1  SCCB engine busy level.
- sccb_done  in  1  1-cycle pulse at end of the write (after STOP).
- cfg_busy  out  1  high from init_req acceptance until DONE.
- cfg_done  out  1  sticky level; table completed.
- cfg_error  out  1  sticky; at least one write timed out.
- cfg_count  out  8  number of completed (or timed-out) writes since the last start.

Behaviour:
- Reset values: state IDLE; rom_addr=0; sccb_start=0; sccb_reg_addr=0; sccb_reg_data=0; cfg_busy=0; cfg_done=0; cfg_error=0; cfg_count=0; all counters 0. Reset mid-transaction aborts immediately; no sccb_start is issued afterwards.
- All outputs are registered.
- Shared ms prescaler: counts 0..CLK_HZ/1000-1 and emits ms_tick at wrap. It is cleared on entry to PWRUP and DELAY.
- IDLE/DONE:
  - On init_req: clear cfg_done, cfg_error, cfg_count; rom_addr=0; cfg_busy=1; go to PWRUP.
  - init_req in any other state is ignored.
- PWRUP: count PWRUP_MS ms_ticks, then go to FETCH. PWRUP_MS=0 goes to FETCH next cycle.
- FETCH: one wait cycle for ROM latency, then DECODE.
- DECODE: register rom_data, then branch on reg_addr:
  - END_CODE: go to DONE.
  - DELAY_CODE: go to DELAY, loading reg_data as the ms count; a count of 0 goes straight to NEXT.
  - Otherwise: latch sccb_reg_addr/sccb_reg_data and go to ISSUE.
- ISSUE:
  - Wait while sccb_busy=1.
  - When sccb_busy=0: sccb_start=1 for exactly one cycle, clear the watchdog, go to WAIT.
- WAIT:
  - sccb_reg_addr/sccb_reg_data are held stable.
  - On sccb_done, go to NEXT.
  - If the watchdog reaches TIMEOUT_CYC-1 without sccb_done: set cfg_error, go to NEXT.
  - sccb_done and timeout in the same cycle counts as done; cfg_error is not set.
- DELAY: count down on ms_tick; at 0 go to NEXT.
- NEXT:
  - cfg_count+1 only if the entry was a write; saturates at 255.
  - If rom_addr==ROM_DEPTH-1, go to DONE with rom_addr unchanged.
  - Else rom_addr+1 and go to FETCH.
- DONE: cfg_busy=0, cfg_done=1. Stay until init_req (restart) or reset.
- sccb_done outside WAIT is ignored.
- Latency per write entry: FETCH(1) + DECODE(1) + ISSUE(≥1) + engine time + NEXT(1).

Test Plan:
- CLK_HZ=4000, PWRUP_MS=2, table 3 writes + END_CODE; init_req -> first sccb_start exactly 8+3 cycles after init_req registered, sccb_reg_addr/data equal each entry in order; cfg_count=3, cfg_done=1, cfg_busy=0, rom_addr=3.
- Entry {F0,03} between two writes -> no sccb_start for 12 cycles (3 ms @4 cycles) after DECODE; cfg_count excludes it; {F0,00} -> no wait.
- Hold sccb_busy=1 for 20 cycles during ISSUE -> sccb_start asserted only on first cycle busy=0, single-cycle.
- TIMEOUT_CYC=50, engine never pulses done on entry 1 -> cfg_error=1 at cycle 50 after start, sequence continues, final cfg_count=table writes, cfg_done=1.
- ROM_DEPTH=4, no END_CODE -> exactly 4 writes, DONE with rom_addr=3; init_req in DONE -> restart clears done/count/error.
- reset asserted mid-WAIT -> all outputs at reset values next cycle; later sccb_done ignored; init_req while busy -> ignored (no counter clear).
